cr_huf_comp_lut_mbank: RTL and testbench

Parametrised multi-bank Huffman code-table buffer, the successor to the fixed two-entry twin-buffer LUT in cr_huf_comp. The header writer fills one bank with N_SYMBOLS code words plus size metadata and a sequence id, then commits it. The symbol-assembly reader reads the oldest committed bank on N_RD_PORTS lanes in parallel, then releases it. Bank count, write lanes, read lanes and widths are generic; the block adds occupancy reporting, overflow and seq-id mismatch flags, which its predecessor does not have.

---
 rtl/cr_huf_comp_lut_mbank.sv | 253 +++++++++++++++++++++++++
 tb/tb_cr_huf_comp_lut_mbank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_huf_comp_lut_mbank.sv
// -----------------------------------------------------------------------------
// cr_huf_comp_lut_mbank
//
// Multi-bank Huffman code-table buffer. The header writer fills the bank at
// wr_ptr (WR_LANES words per beat) and commits it together with its metadata
// and sequence id. The symbol-assembly reader reads the oldest committed bank
// (rd_ptr) on N_RD_PORTS lanes with one cycle of latency, then releases it.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   wr/wr_addr/wr_data  write beat; lane k -> word wr_addr*WR_LANES+k
//   wr_valid_word       per-lane write enable
//   wr_done             commit the fill bank (latches wr_meta_data, wr_seq_id)
//   full, bank_cnt      occupancy (committed, unreleased banks)
//   wr_ovfl             one-cycle pulse when wr/wr_done was dropped while full
//   rd/rd_addr          read request, per-lane word address
//   rd_seq_id           expected sequence id of the oldest bank
//   rd_done             release the oldest bank
//   rd_data/rd_data_val read words, valid one cycle after an accepted rd
//   rd_meta_data/_vld   metadata of the oldest bank, valid while bank_cnt != 0
//   rd_seq_err          seq-id mismatch, pulses with rd_data_val
//   ecc_error           sticky parity error
//
// Optional feature macro: CR_HUF_COMP_LUT_MBANK_PARITY_EN
//   defined   -> one even-parity bit stored per word, checked on every read lane
//   undefined -> no parity storage, ecc_error tied to 0
// -----------------------------------------------------------------------------
module cr_huf_comp_lut_mbank #(
  parameter int N_SYMBOLS   = 576,
  parameter int WORD_WIDTH  = 17,
  parameter int N_BANKS     = 2,
  parameter int WR_LANES    = 2,
  parameter int N_RD_PORTS  = 4,
  parameter int META_WIDTH  = 27,
  parameter int SEQID_WIDTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      wr,
  input  logic [$clog2(N_SYMBOLS/WR_LANES)-1:0]     wr_addr,
  input  logic [WR_LANES*WORD_WIDTH-1:0]            wr_data,
  input  logic [WR_LANES-1:0]                       wr_valid_word,
  input  logic                                      wr_done,
  input  logic [META_WIDTH-1:0]                     wr_meta_data,
  input  logic [SEQID_WIDTH-1:0]                    wr_seq_id,
  output logic                                      full,
  output logic                                      wr_ovfl,
  output logic [$clog2(N_BANKS+1)-1:0]              bank_cnt,
  input  logic                                      rd,
  input  logic [N_RD_PORTS*$clog2(N_SYMBOLS)-1:0]   rd_addr,
  input  logic [SEQID_WIDTH-1:0]                    rd_seq_id,
  input  logic                                      rd_done,
  output logic [N_RD_PORTS*WORD_WIDTH-1:0]          rd_data,
  output logic                                      rd_data_val,
  output logic [META_WIDTH-1:0]                     rd_meta_data,
  output logic                                      rd_meta_vld,
  output logic                                      rd_seq_err,
  output logic                                      ecc_error
);

  localparam int RA = $clog2(N_SYMBOLS);
  localparam int PW = $clog2(N_BANKS);
  localparam int CW = $clog2(N_BANKS+1);
  localparam int MW = $clog2(N_BANKS*N_SYMBOLS);
`ifdef CR_HUF_COMP_LUT_MBANK_PARITY_EN
  localparam int SW = WORD_WIDTH + 1;   // {parity, word}
`else
  localparam int SW = WORD_WIDTH;
`endif

  // Storage array, flat index = bank*N_SYMBOLS + word.
  logic [SW-1:0] mem_q [N_BANKS*N_SYMBOLS];

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          bank_cnt_q, bank_cnt_d;
  logic                   full_q, full_d;
  logic                   wr_ovfl_q, wr_ovfl_d;
  logic [META_WIDTH-1:0]  meta_q [N_BANKS];
  logic [META_WIDTH-1:0]  meta_d [N_BANKS];
  logic [SEQID_WIDTH-1:0] seq_q  [N_BANKS];
  logic [SEQID_WIDTH-1:0] seq_d  [N_BANKS];
  logic [N_RD_PORTS*WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                   rd_data_val_q, rd_data_val_d;
  logic                   rd_seq_err_q, rd_seq_err_d;

  logic          has_bank, wr_acc, commit, rel_acc, rd_acc;
  logic [MW-1:0] wr_base;
  logic [SW-1:0] rd_word [N_RD_PORTS];

  // ---------------------------------------------------------------------------
  // Bank control
  // ---------------------------------------------------------------------------
  // NOTE: combinational logic uses blocking assignments and assigns every
  // output a default first, so no latch can be inferred.
  always_comb begin
    has_bank = (bank_cnt_q != '0);
    wr_acc   = wr & ~full_q;
    rel_acc  = rd_done & has_bank;
    // While full the fill bank is the oldest bank; a commit is only legal if
    // that bank is released in the same cycle.
    commit   = wr_done & (~full_q | rd_done);
    rd_acc   = rd & has_bank;

    wr_ptr_d = wr_ptr_q;
    if (commit) wr_ptr_d = (wr_ptr_q == PW'(N_BANKS-1)) ? '0 : wr_ptr_q + 1'b1;

    rd_ptr_d = rd_ptr_q;
    if (rel_acc) rd_ptr_d = (rd_ptr_q == PW'(N_BANKS-1)) ? '0 : rd_ptr_q + 1'b1;

    bank_cnt_d = bank_cnt_q;
    case ({commit, rel_acc})
      2'b10:   bank_cnt_d = bank_cnt_q + 1'b1;
      2'b01:   bank_cnt_d = bank_cnt_q - 1'b1;
      default: bank_cnt_d = bank_cnt_q;
    endcase

    full_d    = (bank_cnt_d == CW'(N_BANKS));
    wr_ovfl_d = full_q & (wr | (wr_done & ~rd_done));

    for (int b = 0; b < N_BANKS; b++) begin
      meta_d[b] = meta_q[b];
      seq_d[b]  = seq_q[b];
    end
    if (commit) begin
      meta_d[wr_ptr_q] = wr_meta_data;
      seq_d[wr_ptr_q]  = wr_seq_id;
    end

    wr_base = MW'(wr_ptr_q) * MW'(N_SYMBOLS) + MW'(wr_addr) * MW'(WR_LANES);
  end

  // ---------------------------------------------------------------------------
  // Storage write
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; reset only clears the pointers and
  // bank_cnt, which is enough to make every stale word unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int k = 0; k < WR_LANES; k++) begin
        if (wr_valid_word[k]) begin
`ifdef CR_HUF_COMP_LUT_MBANK_PARITY_EN
          mem_q[wr_base + MW'(k)] <= {^wr_data[k*WORD_WIDTH +: WORD_WIDTH],
                                      wr_data[k*WORD_WIDTH +: WORD_WIDTH]};
`else
          mem_q[wr_base + MW'(k)] <= wr_data[k*WORD_WIDTH +: WORD_WIDTH];
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read lanes
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < N_RD_PORTS; j++) begin
      logic [RA-1:0] addr;
      addr = rd_addr[j*RA +: RA];
      // Out-of-range lanes read as zero (and zero parity).
      if (int'(addr) < N_SYMBOLS)
        rd_word[j] = mem_q[MW'(rd_ptr_q) * MW'(N_SYMBOLS) + MW'(addr)];
      else
        rd_word[j] = '0;
    end

    rd_data_d = rd_data_q;     // holds when no read is accepted
    if (rd_acc) begin
      for (int j = 0; j < N_RD_PORTS; j++)
        rd_data_d[j*WORD_WIDTH +: WORD_WIDTH] = rd_word[j][WORD_WIDTH-1:0];
    end
    rd_data_val_d = rd_acc;
    rd_seq_err_d  = rd_acc & (rd_seq_id != seq_q[rd_ptr_q]);
  end

`ifdef CR_HUF_COMP_LUT_MBANK_PARITY_EN
  logic [N_RD_PORTS-1:0] rd_par_q, rd_par_d;
  logic                  ecc_error_q, ecc_error_d;

  always_comb begin
    rd_par_d = rd_par_q;
    if (rd_acc) begin
      for (int j = 0; j < N_RD_PORTS; j++) rd_par_d[j] = rd_word[j][SW-1];
    end
    // Checked on the registered lane data, so a set bit follows rd_data_val.
    ecc_error_d = ecc_error_q;
    if (rd_data_val_q) begin
      for (int j = 0; j < N_RD_PORTS; j++) begin
        if ((^rd_data_q[j*WORD_WIDTH +: WORD_WIDTH]) != rd_par_q[j]) ecc_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_par_q    <= '0;
      ecc_error_q <= 1'b0;
    end else begin
      rd_par_q    <= rd_par_d;
      ecc_error_q <= ecc_error_d;
    end
  end

  assign ecc_error = ecc_error_q;
`else
  assign ecc_error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      bank_cnt_q    <= '0;
      full_q        <= 1'b0;
      wr_ovfl_q     <= 1'b0;
      rd_data_q     <= '0;
      rd_data_val_q <= 1'b0;
      rd_seq_err_q  <= 1'b0;
      for (int b = 0; b < N_BANKS; b++) begin
        meta_q[b] <= '0;
        seq_q[b]  <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      bank_cnt_q    <= bank_cnt_d;
      full_q        <= full_d;
      wr_ovfl_q     <= wr_ovfl_d;
      rd_data_q     <= rd_data_d;
      rd_data_val_q <= rd_data_val_d;
      rd_seq_err_q  <= rd_seq_err_d;
      for (int b = 0; b < N_BANKS; b++) begin
        meta_q[b] <= meta_d[b];
        seq_q[b]  <= seq_d[b];
      end
    end
  end

  assign full         = full_q;
  assign wr_ovfl      = wr_ovfl_q;
  assign bank_cnt     = bank_cnt_q;
  assign rd_data      = rd_data_q;
  assign rd_data_val  = rd_data_val_q;
  assign rd_seq_err   = rd_seq_err_q;
  assign rd_meta_vld  = has_bank;
  assign rd_meta_data = meta_q[rd_ptr_q];

endmodule

// File: tb/tb_cr_huf_comp_lut_mbank.sv
// -----------------------------------------------------------------------------
// Testbench for cr_huf_comp_lut_mbank (default parameters): table-driven read
// vectors plus directed sequences for commit/release/overflow/reset corners.
// -----------------------------------------------------------------------------
module tb_cr_huf_comp_lut_mbank;

  localparam int WW = 17;
  localparam int NS = 576;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr;
  logic [8:0]   wr_addr;
  logic [33:0]  wr_data;
  logic [1:0]   wr_valid_word;
  logic         wr_done;
  logic [26:0]  wr_meta_data;
  logic [3:0]   wr_seq_id;
  logic         full;
  logic         wr_ovfl;
  logic [1:0]   bank_cnt;
  logic         rd;
  logic [3:0][9:0]  rd_addr;
  logic [3:0]   rd_seq_id;
  logic         rd_done;
  logic [67:0]  rd_data;
  logic         rd_data_val;
  logic [26:0]  rd_meta_data;
  logic         rd_meta_vld;
  logic         rd_seq_err;
  logic         ecc_error;

  cr_huf_comp_lut_mbank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_valid_word(wr_valid_word),
    .wr_done      (wr_done),
    .wr_meta_data (wr_meta_data),
    .wr_seq_id    (wr_seq_id),
    .full         (full),
    .wr_ovfl      (wr_ovfl),
    .bank_cnt     (bank_cnt),
    .rd           (rd),
    .rd_addr      (rd_addr),
    .rd_seq_id    (rd_seq_id),
    .rd_done      (rd_done),
    .rd_data      (rd_data),
    .rd_data_val  (rd_data_val),
    .rd_meta_data (rd_meta_data),
    .rd_meta_vld  (rd_meta_vld),
    .rd_seq_err   (rd_seq_err),
    .ecc_error    (ecc_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][9:0]    addr;
    logic [3:0]         seq;
    logic [3:0][WW-1:0] exp;
    logic               err;
  } rd_vec_t;

  rd_vec_t vecs [6];
  int      n_vec = 0;
  int      n_err = 0;
  logic [67:0] last_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fill the current fill bank with word i = base + i; optionally commit on
  // the last beat (write and commit in the same cycle).
  task automatic fill(input logic [WW-1:0] base, input bit do_commit,
                      input logic [26:0] meta, input logic [3:0] seq);
    for (int b = 0; b < NS/2; b++) begin
      wr            = 1'b1;
      wr_addr       = 9'(b);
      wr_data       = {base + WW'(2*b+1), base + WW'(2*b)};
      wr_valid_word = 2'b11;
      wr_done       = do_commit && (b == NS/2-1);
      wr_meta_data  = meta;
      wr_seq_id     = seq;
      tick();
    end
    wr = 1'b0; wr_done = 1'b0; wr_valid_word = 2'b00;
  endtask

  task automatic apply_vec(input int i);
    rd        = 1'b1;
    rd_addr   = vecs[i].addr;
    rd_seq_id = vecs[i].seq;
    tick();
    rd = 1'b0;
    check($sformatf("vec%0d_val", i), rd_data_val, 1'b1);
    check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp);
    check($sformatf("vec%0d_seq_err", i), rd_seq_err, vecs[i].err);
    last_data = vecs[i].exp;
  endtask

  initial begin
    // Bank 0: word i = i, seq 3.  Bank 1: word i = 0x1000+i except word 9.
    vecs[0] = '{addr: {10'd575, 10'd2, 10'd1, 10'd0}, seq: 4'd3,
                exp: {17'd575, 17'd2, 17'd1, 17'd0}, err: 1'b0};
    vecs[1] = '{addr: {10'd288, 10'd287, 10'd10, 10'd600}, seq: 4'd3,
                exp: {17'd288, 17'd287, 17'd10, 17'd0}, err: 1'b0};
    vecs[2] = '{addr: {10'd400, 10'd300, 10'd200, 10'd100}, seq: 4'd5,
                exp: {17'd400, 17'd300, 17'd200, 17'd100}, err: 1'b1};
    vecs[3] = '{addr: {10'd9, 10'd8, 10'd574, 10'd1023}, seq: 4'd3,
                exp: {17'd9, 17'd8, 17'd574, 17'd0}, err: 1'b0};
    vecs[4] = '{addr: {10'd575, 10'd0, 10'd9, 10'd8}, seq: 4'd1,
                exp: {17'h0123F, 17'h01000, 17'h1ABCD, 17'h01008}, err: 1'b0};
    vecs[5] = '{addr: {10'd10, 10'd11, 10'd700, 10'd7}, seq: 4'd4,
                exp: {17'h0100A, 17'h0100B, 17'h0, 17'h01007}, err: 1'b1};

    rst_n = 1'b0; wr = 1'b0; wr_addr = '0; wr_data = '0; wr_valid_word = '0;
    wr_done = 1'b0; wr_meta_data = '0; wr_seq_id = '0;
    rd = 1'b0; rd_addr = '0; rd_seq_id = '0; rd_done = 1'b0;
    last_data = '0;
    tick(); tick();

    // Reset state
    check("rst_full", full, 1'b0);
    check("rst_ovfl", wr_ovfl, 1'b0);
    check("rst_bank_cnt", bank_cnt, 2'd0);
    check("rst_rd_data", rd_data, 68'd0);
    check("rst_rd_val", rd_data_val, 1'b0);
    check("rst_meta_vld", rd_meta_vld, 1'b0);
    check("rst_meta", rd_meta_data, 27'd0);
    check("rst_seq_err", rd_seq_err, 1'b0);
    check("rst_ecc", ecc_error, 1'b0);
    rst_n = 1'b1;
    tick();

    // Bank 0, commit on the last write beat
    fill(17'd0, 1'b1, 27'h155, 4'd3);
    check("b0_bank_cnt", bank_cnt, 2'd1);
    check("b0_meta_vld", rd_meta_vld, 1'b1);
    check("b0_meta", rd_meta_data, 27'h155);
    check("b0_full", full, 1'b0);

    for (int i = 0; i < 4; i++) apply_vec(i);

    // Bank 1 with a partial-lane beat: only word 9 rewritten, word 8 kept
    fill(17'h01000, 1'b0, 27'h0, 4'd0);
    wr = 1'b1; wr_addr = 9'd4; wr_valid_word = 2'b10;
    wr_data = {17'h1ABCD, 17'h1FFFF};
    tick();
    wr = 1'b0; wr_valid_word = 2'b00;
    wr_done = 1'b1; wr_meta_data = 27'h2AA; wr_seq_id = 4'd1;
    tick();
    wr_done = 1'b0;
    check("b1_full", full, 1'b1);
    check("b1_bank_cnt", bank_cnt, 2'd2);

    // Overflow: dropped write (into the oldest bank) and dropped commit
    wr = 1'b1; wr_addr = 9'd4; wr_valid_word = 2'b11;
    wr_data = {17'h15555, 17'h0AAAA}; wr_done = 1'b1;
    wr_meta_data = 27'h7FF; wr_seq_id = 4'd9;
    tick();
    wr = 1'b0; wr_done = 1'b0; wr_valid_word = 2'b00;
    check("ovfl_pulse", wr_ovfl, 1'b1);
    check("ovfl_bank_cnt", bank_cnt, 2'd2);
    check("ovfl_meta", rd_meta_data, 27'h155);
    tick();
    check("ovfl_once", wr_ovfl, 1'b0);

    // Read and release in the same cycle: read sees bank 0 untouched
    rd = 1'b1; rd_done = 1'b1; rd_seq_id = 4'd3;
    rd_addr = {10'd3, 10'd2, 10'd9, 10'd8};
    tick();
    rd = 1'b0; rd_done = 1'b0;
    check("rel_data", rd_data, {17'd3, 17'd2, 17'd9, 17'd8});
    check("rel_seq_err", rd_seq_err, 1'b0);
    check("rel_bank_cnt", bank_cnt, 2'd1);
    check("rel_full", full, 1'b0);
    check("rel_meta", rd_meta_data, 27'h2AA);

    for (int i = 4; i < 6; i++) apply_vec(i);

    // Refill bank 0 -> full, then commit + release in one cycle
    fill(17'h02000, 1'b1, 27'h0AB, 4'd2);
    check("b0b_full", full, 1'b1);
    wr_done = 1'b1; rd_done = 1'b1; wr_meta_data = 27'h3CC; wr_seq_id = 4'd7;
    tick();
    wr_done = 1'b0; rd_done = 1'b0;
    check("cr_bank_cnt", bank_cnt, 2'd2);
    check("cr_full", full, 1'b1);
    check("cr_ovfl", wr_ovfl, 1'b0);
    check("cr_meta", rd_meta_data, 27'h0AB);

    // Seq-id mismatch on bank 0 (stored 2, expected 5)
    rd = 1'b1; rd_seq_id = 4'd5; rd_addr = {10'd3, 10'd2, 10'd1, 10'd0};
    tick();
    rd = 1'b0;
    last_data = {17'h02003, 17'h02002, 17'h02001, 17'h02000};
    check("mm_val", rd_data_val, 1'b1);
    check("mm_err", rd_seq_err, 1'b1);
    check("mm_data", rd_data, last_data);

    // Drain both banks, then read / release while empty
    rd_done = 1'b1;
    tick();
    check("drain1_meta", rd_meta_data, 27'h3CC);
    check("drain1_cnt", bank_cnt, 2'd1);
    tick();
    check("drain2_cnt", bank_cnt, 2'd0);
    check("drain2_meta_vld", rd_meta_vld, 1'b0);
    tick();
    rd_done = 1'b0;
    check("empty_rel_cnt", bank_cnt, 2'd0);
    rd = 1'b1; rd_addr = {10'd0, 10'd0, 10'd0, 10'd0};
    tick();
    rd = 1'b0;
    check("empty_rd_val", rd_data_val, 1'b0);
    check("empty_rd_hold", rd_data, last_data);

    // Reset mid-fill
    for (int b = 0; b < 5; b++) begin
      wr = 1'b1; wr_addr = 9'(b); wr_valid_word = 2'b11; wr_data = {17'h1, 17'h2};
      tick();
    end
    rst_n = 1'b0;
    tick();
    wr = 1'b0; wr_valid_word = 2'b00;
    rst_n = 1'b1;
    check("mrst_cnt", bank_cnt, 2'd0);
    check("mrst_meta_vld", rd_meta_vld, 1'b0);
    check("mrst_rd_data", rd_data, 68'd0);
    check("mrst_full", full, 1'b0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("mrst_rd_val", rd_data_val, 1'b0);

`ifdef CR_HUF_COMP_LUT_MBANK_PARITY_EN
    fill(17'd0, 1'b1, 27'h111, 4'd3);
    dut.mem_q[5] = dut.mem_q[5] ^ 18'h1;
    rd = 1'b1; rd_seq_id = 4'd3; rd_addr = {10'd0, 10'd1, 10'd2, 10'd5};
    tick();
    rd = 1'b0;
    check("par_val", rd_data_val, 1'b1);
    tick();
    check("par_ecc_set", ecc_error, 1'b1);
    tick(); tick(); tick();
    check("par_ecc_sticky", ecc_error, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("par_ecc_rst", ecc_error, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
